// File: rtl/io_ctrl_if.sv
// Bus bundle for io_ctrl: cpu access port, external RAM port, uart rx/tx
// handshakes and status flags. master = surrounding system, slave = io_ctrl.
interface io_ctrl_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_push;
  logic        io_full;
  logic        prog_stop;
  logic        tx_overflow;

  modport master (
    output cpu_a, cpu_wr, cpu_dout, ram_rdata, rx_valid, rx_data, tx_ready,
    input  cpu_din, ram_a, ram_we, ram_wdata, rx_pop, tx_data, tx_push,
           io_full, prog_stop, tx_overflow
  );

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout, ram_rdata, rx_valid, rx_data, tx_ready,
    output cpu_din, ram_a, ram_we, ram_wdata, rx_pop, tx_data, tx_push,
           io_full, prog_stop, tx_overflow
  );
endinterface

// File: rtl/io_ctrl.sv
// CPU-side IO controller: RAM/IO address decode with 2-cycle reads, uart rx
// byte port, cycle-counter snapshot, and a tx FIFO draining into the uart.
module io_ctrl #(
  parameter int TX_AW = 3
) (
  input logic   clk_in,
  input logic   rst_in,
  io_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << TX_AW;
  localparam logic [TX_AW:0] DEPTH_C = (TX_AW+1)'(DEPTH);

  logic [17:0] addr;
  logic [15:0] off;
  logic        is_io;
  logic        rd_io;
  logic        wr_io;
  logic        unused_hi;

  assign addr      = bus.cpu_a[17:0];
  assign off       = addr[15:0];
  assign is_io     = (addr[17:16] == 2'b11);
  assign rd_io     = is_io & ~bus.cpu_wr;
  assign wr_io     = is_io & bus.cpu_wr;
  assign unused_hi = ^bus.cpu_a[31:18];

  assign bus.ram_a     = bus.cpu_a[16:0];
  assign bus.ram_wdata = bus.cpu_dout;
  assign bus.ram_we    = bus.cpu_wr & ~is_io & rst_in;

  logic [31:0] cyc_cnt;
  logic [31:0] snap;
  logic        sel_io_q;
  logic [7:0]  io_byte_q;
  logic [7:0]  io_byte_d;
  logic        snap_take;

  assign bus.rx_pop = rd_io & (off == 16'h0000) & bus.rx_valid & rst_in;
  assign snap_take  = rd_io & (off == 16'h0004);

  // Byte 0 of the counter read is the live value, i.e. the one being latched.
  always_comb begin
    io_byte_d = 8'h00;
    if (rd_io) begin
      case (off)
        16'h0000: io_byte_d = bus.rx_valid ? bus.rx_data : 8'h00;
        16'h0004: io_byte_d = cyc_cnt[7:0];
        16'h0005: io_byte_d = snap[15:8];
        16'h0006: io_byte_d = snap[23:16];
        16'h0007: io_byte_d = snap[31:24];
        default:  io_byte_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cyc_cnt   <= '0;
      snap      <= '0;
      sel_io_q  <= 1'b0;
      io_byte_q <= 8'h00;
    end else begin
      cyc_cnt   <= cyc_cnt + 32'd1;
      sel_io_q  <= is_io;
      io_byte_q <= io_byte_d;
      if (snap_take) snap <= cyc_cnt;
    end
  end

  assign bus.cpu_din = sel_io_q ? io_byte_q : bus.ram_rdata;

  logic [7:0]       fifo_mem [DEPTH];
  logic [TX_AW-1:0] wr_ptr;
  logic [TX_AW-1:0] rd_ptr;
  logic [TX_AW:0]   count;
  logic             full;
  logic             push_req;
  logic             push_ok;
  logic [7:0]       push_byte;
  logic             drain;
  logic             stop_wr;
  logic             prog_stop_q;
  logic             tx_overflow_q;

  assign stop_wr   = wr_io & (off == 16'h0004);
  assign push_req  = (wr_io & (off == 16'h0000) & (bus.cpu_dout != 8'h00)) | stop_wr;
  assign push_byte = stop_wr ? 8'h00 : bus.cpu_dout;
  assign full      = (count == DEPTH_C);
  // Acceptance looks only at the count at the start of the cycle, so a
  // push into a full FIFO is dropped even if a drain happens in the same cycle.
  assign push_ok   = push_req & ~full;
  assign drain     = (count != '0) & bus.tx_ready;

  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      prog_stop_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (drain)   rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stop_wr)           prog_stop_q   <= 1'b1;
      if (push_req && full)  tx_overflow_q <= 1'b1;
    end
  end

  assign bus.tx_data     = fifo_mem[rd_ptr];
  assign bus.tx_push     = drain;
  assign bus.io_full     = full;
  assign bus.prog_stop   = prog_stop_q;
  assign bus.tx_overflow = tx_overflow_q;
endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the CPU/IO/FIFO behaviour.
module tb_io_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_ctrl_if bus_if();
  io_ctrl #(.TX_AW(3)) dut (.clk_in(clk), .rst_in(rst_n), .bus(bus_if.slave));

  int checks = 0;
  int failures = 0;

  byte unsigned fifo_q[$];
  byte unsigned dut_sent[$];
  bit           stop_m, ovf_m;
  bit [31:0]    cnt_m, snap_m;
  bit           rd_pend, rd_io_pend;
  byte unsigned rd_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus_if.cpu_a    = 32'h0;
    bus_if.cpu_wr   = 1'b0;
    bus_if.cpu_dout = 8'h00;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.tx_ready = 1'b0;
    bus_if.ram_rdata = 8'($urandom);
  endtask

  // One bus cycle: drive after the edge, check and advance the model at negedge.
  task automatic tick(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic rxv, input logic [7:0] rxd, input logic txr);
    logic [15:0] off;
    bit io, req;
    byte unsigned pb;
    int start_sz;
    bus_if.cpu_a     = a;
    bus_if.cpu_wr    = wr;
    bus_if.cpu_dout  = d;
    bus_if.rx_valid  = rxv;
    bus_if.rx_data   = rxd;
    bus_if.tx_ready  = txr;
    bus_if.ram_rdata = 8'($urandom);
    @(negedge clk);
    io  = (a[17:16] == 2'b11);
    off = a[15:0];
    start_sz = fifo_q.size();
    if (rd_pend) chk(rd_io_pend ? "cpu_din_io" : "cpu_din_ram", bus_if.cpu_din,
                     rd_io_pend ? 32'(rd_exp) : 32'(bus_if.ram_rdata));
    chk("ram_a", bus_if.ram_a, {15'b0, a[16:0]});
    chk("ram_we", bus_if.ram_we, wr && !io);
    chk("ram_wdata", bus_if.ram_wdata, d);
    chk("rx_pop", bus_if.rx_pop, !wr && io && off == 16'h0 && rxv);
    chk("io_full", bus_if.io_full, start_sz == 8);
    chk("tx_push", bus_if.tx_push, start_sz > 0 && txr);
    if (start_sz > 0 && txr) chk("tx_data", bus_if.tx_data, fifo_q[0]);
    chk("prog_stop", bus_if.prog_stop, stop_m);
    chk("tx_overflow", bus_if.tx_overflow, ovf_m);
    if (bus_if.tx_push === 1'b1) dut_sent.push_back(bus_if.tx_data);
    rd_pend = !wr;
    rd_io_pend = io;
    rd_exp = 8'h00;
    if (!wr && io) begin
      case (off)
        16'h0000: rd_exp = rxv ? rxd : 8'h00;
        16'h0004: begin snap_m = cnt_m; rd_exp = cnt_m[7:0]; end
        16'h0005: rd_exp = snap_m[15:8];
        16'h0006: rd_exp = snap_m[23:16];
        16'h0007: rd_exp = snap_m[31:24];
        default:  rd_exp = 8'h00;
      endcase
    end
    if (start_sz > 0 && txr) void'(fifo_q.pop_front());
    req = 0; pb = 0;
    if (wr && io && off == 16'h0 && d != 8'h00) begin req = 1; pb = d; end
    if (wr && io && off == 16'h4) begin req = 1; pb = 8'h00; stop_m = 1; end
    if (req) begin
      if (start_sz < 8) fifo_q.push_back(pb);
      else ovf_m = 1;
    end
    @(posedge clk);
    #1;
    cnt_m++;
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) tick(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, txr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    bus_if.cpu_a = 32'h0003_0000;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data = 8'hA5;
    bus_if.tx_ready = 1'b1;
    #2;
    chk("rst_cpu_din", bus_if.cpu_din, bus_if.ram_rdata);
    chk("rst_rx_pop", bus_if.rx_pop, 1'b0);
    chk("rst_tx_push", bus_if.tx_push, 1'b0);
    chk("rst_io_full", bus_if.io_full, 1'b0);
    bus_if.cpu_a = 32'h0000_0010;
    bus_if.cpu_wr = 1'b1;
    #1;
    chk("rst_ram_we", bus_if.ram_we, 1'b0);
    @(posedge clk);
    #1;
    set_idle();
    rst_n = 1'b1;
    fifo_q.delete();
    dut_sent.delete();
    stop_m = 0; ovf_m = 0; cnt_m = 0; snap_m = 0;
    rd_pend = 0; rd_io_pend = 0; rd_exp = 0;
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] offs [7];
    offs = '{16'h0, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'h1};

    do_reset();
    chk("rst_prog_stop", bus_if.prog_stop, 1'b0);
    chk("rst_overflow", bus_if.tx_overflow, 1'b0);

    // zero bytes to the data port are never sent
    tick(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    tick(32'h0003_0000, 1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
    tick(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    tick(32'h0003_0000, 1'b1, 8'h43, 1'b0, 8'h00, 1'b1);
    idle(4, 1'b1);
    chk("seq_len", dut_sent.size(), 3);
    if (dut_sent.size() == 3) begin
      chk("seq_0", dut_sent[0], 8'h41);
      chk("seq_1", dut_sent[1], 8'h42);
      chk("seq_2", dut_sent[2], 8'h43);
    end

    // fill, overflow, then ordered drain
    do_reset();
    for (int i = 1; i <= 9; i++) tick(32'h0003_0000, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
    chk("ovf_full", bus_if.io_full, 1'b1);
    chk("ovf_flag", bus_if.tx_overflow, 1'b1);
    dut_sent.delete();
    idle(10, 1'b1);
    chk("drain_len", dut_sent.size(), 8);
    for (int i = 0; i < 8 && i < dut_sent.size(); i++) chk("drain_byte", dut_sent[i], 8'(i + 1));
    chk("drain_empty", bus_if.io_full, 1'b0);

    // counter snapshot at cycle 100
    do_reset();
    while (cnt_m != 32'd100) idle(1, 1'b0);
    tick(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1 chk("snap_b0", bus_if.cpu_din, 8'h64);
    idle(3, 1'b0);
    tick(32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1 chk("snap_b1", bus_if.cpu_din, 8'h00);
    idle(7, 1'b0);
    tick(32'h0003_0006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick(32'h0003_0007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1 chk("snap_b3", bus_if.cpu_din, 8'h00);

    // uart rx port
    tick(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
    #1 chk("rx_byte", bus_if.cpu_din, 8'h5A);
    tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0);
    #1 chk("rx_empty", bus_if.cpu_din, 8'h00);

    // back-to-back RAM then IO read
    tick(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
    tick(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
    idle(2, 1'b0);

    // program stop and reset in the middle of a drain
    tick(32'h0003_0000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    tick(32'h0003_0000, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    tick(32'h0003_0004, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
    chk("stop_set", bus_if.prog_stop, 1'b1);
    idle(1, 1'b1);
    bus_if.tx_ready = 1'b1;
    #2 chk("pre_rst_push", bus_if.tx_push, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_push", bus_if.tx_push, 1'b0);
    chk("mid_rst_stop", bus_if.prog_stop, 1'b0);
    chk("mid_rst_full", bus_if.io_full, 1'b0);
    do_reset();
    idle(2, 1'b1);
    chk("post_rst_sent", dut_sent.size(), 0);
    tick(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(3, 1'b1);
    chk("stop_sent_len", dut_sent.size(), 1);
    if (dut_sent.size() == 1) chk("stop_sent_zero", dut_sent[0], 8'h00);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      a = $urandom;
      if ($urandom_range(0, 9) < 6) begin
        a[17:16] = 2'b11;
        a[15:0]  = offs[$urandom_range(0, 6)];
      end else begin
        a[17:16] = 2'($urandom_range(0, 2));
      end
      tick(a, $urandom_range(0, 2) == 0,
           ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
           1'($urandom), 8'($urandom),
           (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 SHALL have parameter TX_AW, default 3, giving tx FIFO depth 2^TX_AW = 8 entries.
REQ-002 SHALL have port clk_in  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports cpu_a  input  32  byte address from cpu; only bits 17:0 decoded.
REQ-005 SHALL have ports cpu_wr  input  1  write strobe (1 = write); cpu_dout  input  8  write byte.
REQ-006 SHALL have port cpu_din  output  8  read byte returned to cpu.
REQ-007 SHALL have ports ram_a  output  17  RAM address; ram_we  output  1  RAM write enable; ram_wdata  output  8; ram_rdata  input  8.
REQ-008 SHALL have ports rx_valid  input  1  uart byte available; rx_data  input  8; rx_pop  output  1  one-cycle consume strobe.
REQ-009 SHALL have ports tx_ready  input  1  uart accepts a byte; tx_data  output  8; tx_push  output  1.
REQ-010 SHALL have ports io_full  output  1  tx FIFO full; prog_stop  output  1  sticky program-end flag; tx_overflow  output  1  sticky drop flag.

Function
REQ-011 SHALL decode region IO when cpu_a[17:16] == 2'b11, else RAM.
REQ-012 SHALL drive ram_a = cpu_a[16:0] and ram_wdata = cpu_dout combinationally; ram_we = cpu_wr & region RAM.
REQ-013 SHALL return read data one cycle after the address cycle (2-cycle read): a registered region/offset select from cycle t picks cpu_din at t+1.
REQ-014 SHALL at t+1 present ram_rdata when the registered region is RAM, else the registered IO byte captured at t.
REQ-015 SHALL, on read of 0x30000 with rx_valid=1, capture rx_data and pulse rx_pop for exactly that cycle; with rx_valid=0, return 0x00 and no pop.
REQ-016 SHALL keep a 32-bit free-running cycle counter, 0 at reset, +1 every cycle, wrapping 0xFFFFFFFF -> 0.
REQ-017 SHALL, on read of 0x30004, latch the counter into a 32-bit snapshot and return snapshot byte 0 (LSB, the value being latched); reads of 0x30005/6/7 return snapshot bytes 1/2/3 without relatching.
REQ-018 SHALL, on write of 0x30000 with cpu_dout != 0x00, push cpu_dout into the tx FIFO; writing 0x00 is ignored.
REQ-019 SHALL, on write of 0x30004, push 0x00 into the tx FIFO and set prog_stop on the next edge; prog_stop stays high until reset.
REQ-020 SHALL accept a push iff FIFO count < 2^TX_AW at the start of the cycle; a rejected push discards the byte and sets tx_overflow (sticky).
REQ-021 SHALL assert io_full combinationally when count == 2^TX_AW.
REQ-022 SHALL drain: when FIFO nonempty and tx_ready=1, tx_data = head entry and tx_push = 1 for that cycle; head advances on the edge.
REQ-023 SHALL handle simultaneous push and drain in one cycle: count unchanged, both pointers advance; pointers wrap modulo 2^TX_AW.
REQ-024 SHALL preserve FIFO order exactly; no byte duplicated or reordered.
REQ-025 SHALL ignore IO reads/writes to other offsets (read returns 0x00, no side effects).

Reset
REQ-026 SHALL, while rst_in = 0, asynchronously clear counter, snapshot, FIFO pointers/count, registered select (to RAM), IO byte, prog_stop, tx_overflow.
REQ-027 SHALL drive during reset: cpu_din = ram_rdata path, rx_pop = 0, tx_push = 0, io_full = 0, ram_we = 0.
REQ-028 SHALL discard FIFO contents on reset mid-drain; first cycle after release behaves as empty.

Verification
REQ-029 SHALL cover: write 0x41,0x42,0x00,0x43 to 0x30000 with tx_ready=1 -> tx_push sequence 0x41,0x42,0x43; 0x00 never sent.
REQ-030 SHALL cover: tx_ready=0, nine writes 0x01..0x09 -> io_full after 8th, 0x09 dropped, tx_overflow=1; release tx_ready -> 0x01..0x08 in order.
REQ-031 SHALL cover: release reset, read 0x30004 at cycle 100 then 0x30005..7 -> bytes form 100 (0x64,0,0,0) regardless of read cycles.
REQ-032 SHALL cover: rx_valid=1 rx_data=0x5A, read 0x30000 -> one rx_pop pulse, cpu_din=0x5A next cycle; rx_valid=0 -> 0x00, no pop.
REQ-033 SHALL cover: RAM read 0x00010 then IO read 0x30000 back-to-back -> cpu_din shows ram_rdata then IO byte on consecutive cycles.
REQ-034 SHALL cover: write 0x30004 -> 0x00 transmitted, prog_stop=1; assert rst_in=0 mid-drain -> prog_stop, count, tx_push cleared immediately.
